// File: rtl/bus_arbiter_2m_pkg.sv
// Shared bus types and arbiter state encoding.
// Used by the two-master arbiter and its bus interface.
package bus_arbiter_2m_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic LAST_M1 = 1'b1;

  function automatic logic [1:0] onehot2(
    input logic sel
  );
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// Single-transaction bus between a master and a slave.
// The arbiter faces masters through .slave and the slave through .master.
interface bus_arbiter_2m_if
  import bus_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              breq;
  logic              bstart;
  ttype_e            ttype;
  tsize_e            tsize;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              bdone;
  logic              berr;

  modport master (
    output breq, bstart, ttype, tsize,
    output addr, wdata,
    input  rdata, bdone, berr
  );

  modport slave (
    input  breq, bstart, ttype, tsize,
    input  addr, wdata,
    output rdata, bdone, berr
  );

endinterface

// File: rtl/bus_arbiter_2m_pick.sv
// Combinational winner selection for the two-master arbiter.
// Returns a one-hot grant, or zero when nobody requests.
module arb_pick #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (PRIORITY_MODE != 0) begin
      if (req_i[1]) begin
        gnt_o = 2'b10;
      end else if (req_i[0]) begin
        gnt_o = 2'b01;
      end
    end else begin
      unique case (req_i)
        2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
        2'b10:   gnt_o = 2'b10;
        2'b01:   gnt_o = 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/bus_arbiter_2m.sv
// Two-master, one-slave bus arbiter with per-transaction grant
// and slave-response timeout.
module bus_arbiter_2m
  import bus_arbiter_2m_pkg::*;
#(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_arbiter_2m_if.slave  m0_if,
  bus_arbiter_2m_if.slave  m1_if,
  bus_arbiter_2m_if.master s_if,
  output logic [1:0]       grant_o,
  output logic             timeout_o
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_gnt;
  logic              sel;
  logic              to_hit;
  logic              fin;
  logic              err;
  logic [1:0]        pick;
  ttype_e            ttype_mux;
  tsize_e            tsize_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign in_gnt = (state_q != IDLE);
  assign sel    = (state_q == GNT1);
  assign to_hit = TO_EN && in_gnt && (cnt_q == CNT_MAX);
  // A slave completion in the timeout cycle is a normal finish.
  assign fin    = in_gnt && (s_if.bdone || to_hit);
  assign err    = to_hit && !s_if.bdone;
  assign last_d = fin ? sel : last_q;

  arb_pick #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_pick (
    .req_i ({m1_if.breq, m0_if.breq}),
    .last_i(last_d),
    .gnt_o (pick)
  );

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    cnt_d     = '0;
    grant_o   = 2'b00;
    ttype_mux = READ;
    tsize_mux = BYTE;
    addr_mux  = '0;
    wdata_mux = '0;
    if (fin || !in_gnt) begin
      unique case (1'b1)
        pick[1]: state_d = GNT1;
        pick[0]: state_d = GNT0;
        default: state_d = IDLE;
      endcase
      start_d = |pick;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      GNT0: begin
        grant_o   = onehot2(1'b0);
        ttype_mux = m0_if.ttype;
        tsize_mux = m0_if.tsize;
        addr_mux  = m0_if.addr;
        wdata_mux = m0_if.wdata;
      end
      GNT1: begin
        grant_o   = onehot2(1'b1);
        ttype_mux = m1_if.ttype;
        tsize_mux = m1_if.tsize;
        addr_mux  = m1_if.addr;
        wdata_mux = m1_if.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_M1;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_if.breq   = in_gnt;
  assign s_if.bstart = start_q;
  assign s_if.ttype  = ttype_mux;
  assign s_if.tsize  = tsize_mux;
  assign s_if.addr   = addr_mux;
  assign s_if.wdata  = wdata_mux;

  assign m0_if.rdata = s_if.rdata;
  assign m1_if.rdata = s_if.rdata;
  assign m0_if.bdone = fin && !sel;
  assign m1_if.bdone = fin && sel;
  assign m0_if.berr  = err && !sel;
  assign m1_if.berr  = err && sel;
  assign timeout_o   = err;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Bench for bus_arbiter_2m: a round-robin (timeout 4) and a fixed
// (timeout 3) instance, each checked against a transaction model.
module tb_bus_arbiter_2m;
  import bus_arbiter_2m_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic          breq  [2][2];
  logic          keep  [2][2];
  ttype_e        tt    [2][2];
  tsize_e        ts    [2][2];
  logic [AW-1:0] ad    [2][2];
  logic [DW-1:0] wd    [2][2];
  logic [DW-1:0] srd   [2];
  logic          sbd   [2];

  logic [DW-1:0] o_rd  [2][2];
  logic          o_bd  [2][2];
  logic          o_be  [2][2];
  logic          o_sbq [2];
  logic          o_sbs [2];
  ttype_e        o_tt  [2];
  tsize_e        o_ts  [2];
  logic [AW-1:0] o_ad  [2];
  logic [DW-1:0] o_wd  [2];
  logic [1:0]    o_gnt [2];
  logic          o_to  [2];

  int own [2];
  int age [2];
  int lst [2];
  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    bus_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    bus_arbiter_2m_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

    assign m0_if.breq   = breq[g][0];
    assign m0_if.bstart = 1'b0;
    assign m0_if.ttype  = tt[g][0];
    assign m0_if.tsize  = ts[g][0];
    assign m0_if.addr   = ad[g][0];
    assign m0_if.wdata  = wd[g][0];
    assign m1_if.breq   = breq[g][1];
    assign m1_if.bstart = 1'b0;
    assign m1_if.ttype  = tt[g][1];
    assign m1_if.tsize  = ts[g][1];
    assign m1_if.addr   = ad[g][1];
    assign m1_if.wdata  = wd[g][1];
    assign s_if.rdata   = srd[g];
    assign s_if.bdone   = sbd[g];
    assign s_if.berr    = 1'b0;

    bus_arbiter_2m #(
      .PRIORITY_MODE (g),
      .TIMEOUT_CYCLES(g == 0 ? 4 : 3),
      .ADDR_W        (AW),
      .DATA_W        (DW)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .m0_if    (m0_if),
      .m1_if    (m1_if),
      .s_if     (s_if),
      .grant_o  (o_gnt[g]),
      .timeout_o(o_to[g])
    );

    assign o_rd[g][0] = m0_if.rdata;
    assign o_rd[g][1] = m1_if.rdata;
    assign o_bd[g][0] = m0_if.bdone;
    assign o_bd[g][1] = m1_if.bdone;
    assign o_be[g][0] = m0_if.berr;
    assign o_be[g][1] = m1_if.berr;
    assign o_sbq[g]   = s_if.breq;
    assign o_sbs[g]   = s_if.bstart;
    assign o_tt[g]    = s_if.ttype;
    assign o_ts[g]    = s_if.tsize;
    assign o_ad[g]    = s_if.addr;
    assign o_wd[g]    = s_if.wdata;
  end

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int tmo(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // d0 is round-robin, d1 always prefers m1.
  function automatic int pick_m(int d, logic r0, logic r1);
    if (d == 1) return r1 ? 1 : (r0 ? 0 : -1);
    if (r0 && r1) return 1 - lst[d];
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic void mdl_reset(int d);
    own[d] = -1;
    age[d] = 0;
    lst[d] = 1;
  endfunction

  task automatic compare(int d);
    int            n;
    bit            to, bd, er;
    logic [1:0]    g;
    logic [63:0]   e_tt, e_ts, e_ad, e_wd;
    string         p;
    if (!rst_n[d]) mdl_reset(d);
    n  = own[d];
    to = (n >= 0) && (age[d] == tmo(d));
    bd = (n >= 0) && (sbd[d] || to);
    er = to && !sbd[d];
    g  = '0;
    e_tt = '0; e_ts = '0; e_ad = '0; e_wd = '0;
    if (n >= 0) begin
      g    = (n == 0) ? 2'b01 : 2'b10;
      e_tt = 64'(tt[d][n]);
      e_ts = 64'(ts[d][n]);
      e_ad = 64'(ad[d][n]);
      e_wd = 64'(wd[d][n]);
    end
    p = $sformatf("d%0d", d);
    chk({p, " grant"},   64'(o_gnt[d]), 64'(g));
    chk({p, " s_breq"},  64'(o_sbq[d]), 64'(n >= 0));
    chk({p, " s_bstart"}, 64'(o_sbs[d]),
        64'((n >= 0) && (age[d] == 1)));
    chk({p, " s_ttype"}, 64'(o_tt[d]), e_tt);
    chk({p, " s_tsize"}, 64'(o_ts[d]), e_ts);
    chk({p, " s_addr"},  64'(o_ad[d]), e_ad);
    chk({p, " s_wdata"}, 64'(o_wd[d]), e_wd);
    chk({p, " timeout"}, 64'(o_to[d]), 64'(er));
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s m%0d bdone", p, m),
          64'(o_bd[d][m]), 64'(bd && n == m));
      chk($sformatf("%s m%0d berr", p, m),
          64'(o_be[d][m]), 64'(er && n == m));
      chk($sformatf("%s m%0d rdata", p, m),
          64'(o_rd[d][m]), 64'(srd[d]));
    end
  endtask

  function automatic void update(int d);
    if (!rst_n[d]) begin
      mdl_reset(d);
      return;
    end
    if (own[d] >= 0) begin
      if (!(sbd[d] || age[d] == tmo(d))) begin
        age[d]++;
        return;
      end
      lst[d] = own[d];
    end
    own[d] = pick_m(d, breq[d][0], breq[d][1]);
    age[d] = 1;
  endfunction

  // Masters release breq on their bdone unless told to keep requesting.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) compare(d);
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++)
        if (breq[d][m] && o_bd[d][m] && !keep[d][m])
          breq[d][m] = 1'b0;
    @(posedge clk);
    for (int d = 0; d < 2; d++) update(d);
    #1;
  endtask

  task automatic set_req(int m, ttype_e t, tsize_e s,
                         logic [AW-1:0] a, logic [DW-1:0] w);
    for (int d = 0; d < 2; d++) begin
      breq[d][m] = 1'b1;
      tt[d][m]   = t;
      ts[d][m]   = s;
      ad[d][m]   = a;
      wd[d][m]   = w;
    end
  endtask

  task automatic set_all(logic bd, logic kp);
    for (int d = 0; d < 2; d++) begin
      sbd[d] = bd;
      for (int m = 0; m < 2; m++) keep[d][m] = kp;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1;
      srd[d]   = '0;
      sbd[d]   = 1'b0;
      mdl_reset(d);
      for (int m = 0; m < 2; m++) begin
        breq[d][m] = 1'b0;
        keep[d][m] = 1'b0;
        tt[d][m]   = READ;
        ts[d][m]   = BYTE;
        ad[d][m]   = '0;
        wd[d][m]   = '0;
      end
    end
    #2;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    chk("reset grant", 64'(o_gnt[0]), 64'(2'b00));
    chk("reset s_breq", 64'(o_sbq[1]), 64'(1'b0));
    step();
    step();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();

    // Single read; on d1 the done lands on the timeout cycle.
    set_req(0, READ, WORD, 32'h100, 32'h0);
    step();
    chk("single grant", 64'(o_gnt[0]), 64'(2'b01));
    chk("single bstart", 64'(o_sbs[0]), 64'(1'b1));
    chk("single addr", 64'(o_ad[0]), 64'h100);
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      sbd[d] = 1'b1;
      srd[d] = 32'hDEADBEEF;
    end
    #1;
    chk("single m0_bdone", 64'(o_bd[0][0]), 64'(1'b1));
    chk("single m0_rdata", 64'(o_rd[0][0]), 64'hDEADBEEF);
    chk("single m1_bdone", 64'(o_bd[0][1]), 64'(1'b0));
    chk("coinc bdone", 64'(o_bd[1][0]), 64'(1'b1));
    chk("coinc berr", 64'(o_be[1][0]), 64'(1'b0));
    chk("coinc timeout", 64'(o_to[1]), 64'(1'b0));
    step();
    set_all(1'b0, 1'b0);
    step();

    // Continuous contention with one-cycle slave.
    set_all(1'b1, 1'b1);
    set_req(0, READ, HALF, 32'h200, 32'h0);
    set_req(1, WRITE, WORD, 32'h300, 32'hCAFE);
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr grant %0d", i), 64'(o_gnt[0]),
          64'((i % 2 == 0) ? 2'b10 : 2'b01));
      chk($sformatf("rr bstart %0d", i), 64'(o_sbs[0]), 64'(1'b1));
      chk($sformatf("fix grant %0d", i), 64'(o_gnt[1]),
          64'(2'b10));
      step();
    end
    keep[0][1] = 1'b0;
    keep[1][1] = 1'b0;
    step();
    chk("rr after drop", 64'(o_gnt[0]), 64'(2'b01));
    chk("fix after drop", 64'(o_gnt[1]), 64'(2'b01));
    keep[0][0] = 1'b0;
    keep[1][0] = 1'b0;
    step();
    set_all(1'b0, 1'b0);
    step();

    // Silent slave: timeout hands the grant to pending m1.
    set_req(0, READ, WORD, 32'h400, 32'h0);
    step();
    set_req(1, WRITE, BYTE, 32'h500, 32'h55);
    step();
    step();
    step();
    chk("to m0_bdone", 64'(o_bd[0][0]), 64'(1'b1));
    chk("to m0_berr", 64'(o_be[0][0]), 64'(1'b1));
    chk("to timeout", 64'(o_to[0]), 64'(1'b1));
    step();
    chk("to next grant", 64'(o_gnt[0]), 64'(2'b10));

    // Asynchronous reset while m1 holds the grant.
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    chk("rst grant", 64'(o_gnt[0]), 64'(2'b00));
    chk("rst s_breq", 64'(o_sbq[0]), 64'(1'b0));
    chk("rst addr", 64'(o_ad[0]), 64'h0);
    chk("rst m1_bdone", 64'(o_bd[0][1]), 64'(1'b0));
    set_req(0, READ, WORD, 32'h600, 32'h0);
    step();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();
    chk("post-rst rr grant", 64'(o_gnt[0]), 64'(2'b01));
    chk("post-rst fix grant", 64'(o_gnt[1]), 64'(2'b10));
    set_all(1'b1, 1'b0);
    step();
    step();
    step();
    set_all(1'b0, 1'b0);

    // Random traffic, including withdrawn requests and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst_n[d] = ($urandom_range(399, 0) != 0);
        sbd[d]   = ($urandom_range(2, 0) == 0);
        srd[d]   = $urandom;
        for (int m = 0; m < 2; m++) begin
          keep[d][m] = $urandom_range(1, 0) == 1;
          if (!breq[d][m] && $urandom_range(2, 0) == 0) begin
            breq[d][m] = 1'b1;
            tt[d][m]   = ttype_e'($urandom_range(1, 0));
            ts[d][m]   = tsize_e'($urandom_range(2, 0));
            ad[d][m]   = $urandom;
            wd[d][m]   = $urandom;
          end else if (breq[d][m] && $urandom_range(63, 0) == 0) begin
            breq[d][m] = 1'b0;
          end
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
